// File: rtl/bram_word_reader_pkg.sv
// Shared constants for the byte-RAM word reader: FSM encodings and word geometry.
package bram_word_reader_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned CNT_W      = 2;

endpackage

// File: rtl/bram_word_reader.sv
// Fetches a 32-bit little-endian word from a byte-wide block RAM as four byte reads.
// Optional macro BRAM_WORD_READER_ALIGN_CHECK_EN rejects requests with i_addr[1:0] != 0.
module bram_word_reader
    import bram_word_reader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic [31:0]           o_word,
    output logic                  o_re,
    output logic [ADDR_WIDTH-1:0] o_raddr,
    input  logic [7:0]            i_rdata
);

    logic [1:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic [23:0]           shadow;
    logic [31:0]           word;
    logic                  re;
    logic [ADDR_WIDTH-1:0] raddr;
    logic                  done;
`ifdef BRAM_WORD_READER_ALIGN_CHECK_EN
    logic                  err;
`endif

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_BYTES - 1);

    // The RAM output changes on the falling edge, so the byte for the address
    // driven in cycle cnt is stable at the rising edge that ends that cycle.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            shadow <= '0;
            word   <= '0;
            re     <= 1'b0;
            raddr  <= '0;
            done   <= 1'b0;
`ifdef BRAM_WORD_READER_ALIGN_CHECK_EN
            err    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef BRAM_WORD_READER_ALIGN_CHECK_EN
            err  <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
`ifdef BRAM_WORD_READER_ALIGN_CHECK_EN
                        if (i_addr[1:0] != 2'b00) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state <= ST_READ;
                            cnt   <= '0;
                            re    <= 1'b1;
                            raddr <= i_addr;
                        end
`else
                        state <= ST_READ;
                        cnt   <= '0;
                        re    <= 1'b1;
                        raddr <= i_addr;
`endif
                    end
                end
                ST_READ: begin
                    case (cnt)
                        2'd0:    shadow[7:0]   <= i_rdata;
                        2'd1:    shadow[15:8]  <= i_rdata;
                        2'd2:    shadow[23:16] <= i_rdata;
                        default: ;
                    endcase
                    if (cnt == LAST_CNT) begin
                        word  <= {i_rdata, shadow};
                        re    <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        cnt   <= cnt + CNT_W'(1);
                        // Address arithmetic wraps naturally at 2**ADDR_WIDTH.
                        raddr <= raddr + ADDR_WIDTH'(1);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy  = (state == ST_READ) || (state == ST_DONE);
    assign o_done  = done;
    assign o_word  = word;
    assign o_re    = re;
    assign o_raddr = raddr;
`ifdef BRAM_WORD_READER_ALIGN_CHECK_EN
    assign o_err   = err;
`else
    assign o_err   = 1'b0;
`endif

endmodule
